// File: rtl/reflex_judge.sv
// Reflex judge: arms on a presented target lane, judges the first new key press
// (or a timeout) as hit or miss, and tallies misses up to a sticky game_over.
module reflex_judge #(
  parameter int LANES    = 8,
  parameter int WINDOW   = 16,
  parameter int MAX_MISS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             target_valid,
  input  logic [LANES-1:0] target,
  input  logic [LANES-1:0] keys,
  output logic             busy,
  output logic             hit,
  output logic             miss,
  output logic [2:0]       miss_count,
  output logic             game_over
);

  localparam int TW = 24;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW - 1);
  localparam logic [2:0]    MAX_CNT    = 3'(MAX_MISS);

  typedef enum logic [1:0] {IDLE, ARMED, OVER} state_t;

  state_t           state;
  logic [LANES-1:0] tgt;
  logic [LANES-1:0] key_prev;
  logic [LANES-1:0] key_edge;
  logic [TW-1:0]    timer;
  logic             judged_hit;
  logic             judged_miss;
  logic [2:0]       count_next;

  // Only rising key edges count, so a key already held at arm time is ignored.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_edge
      assign key_edge[gi] = keys[gi] & ~key_prev[gi];
    end
  endgenerate

  assign busy = (state == ARMED);

  // A press on the timer==0 cycle is judged as a press, not a timeout.
  always_comb begin
    judged_hit  = 1'b0;
    judged_miss = 1'b0;
    if (state == ARMED) begin
      if (key_edge != '0) begin
        judged_hit  = (key_edge == tgt);
        judged_miss = (key_edge != tgt);
      end else if (timer == '0) begin
        judged_miss = 1'b1;
      end
    end
  end

  assign count_next = (miss_count == MAX_CNT) ? miss_count : miss_count + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= '0;
      key_prev   <= '0;
      timer      <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      miss_count <= '0;
      game_over  <= 1'b0;
    end else begin
      key_prev <= keys;
      hit      <= 1'b0;
      miss     <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        tgt        <= '0;
        timer      <= '0;
        miss_count <= '0;
        game_over  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (target_valid && target != '0 && !game_over) begin
              tgt   <= target;
              timer <= TIMER_LOAD;
              state <= ARMED;
            end
          end
          ARMED: begin
            if (judged_hit) begin
              hit   <= 1'b1;
              timer <= '0;
              state <= IDLE;
            end else if (judged_miss) begin
              miss       <= 1'b1;
              timer      <= '0;
              miss_count <= count_next;
              if (count_next == MAX_CNT) begin
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                state <= IDLE;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
